instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch unit on the instruction-memory side of the program counter. It takes the current 8-bit program address and reads the two bytes of a 16-bit instruction from a byte-wide instruction memory, using a ready handshake. It assembles the bytes into the instruction register and pulses `inc_pc` so the program counter advances by 2. It sits between the program counter, the instruction memory and the control unit, which issues `fetch_req` and `flush`.

## Interface
Parameters:
- `ADDR_W`, default 8: program/memory address width.
- `WAIT_TIMEOUT`, default 15: maximum cycles to wait for `mem_ready` per byte before `fetch_err` is raised.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, asynchronous, active-high.
- `fetch_req`, in, 1: start a fetch at `pc_addr`. Sampled only in IDLE.
- `pc_addr`, in, ADDR_W: program counter value. Latched when `fetch_req` is accepted.
- `flush`, in, 1: abort any in-progress fetch (redirect/LoadPC).
- `mem_addr`, out, ADDR_W: byte address to instruction memory.
- `mem_rd`, out, 1: read request. Held high with `mem_addr` stable until `mem_ready`.
- `mem_rdata`, in, 8: read byte. Valid in the cycle `mem_ready=1`.
- `mem_ready`, in, 1: memory completes the current read.
- `ir`, out, 16: instruction register. Holds its value until the next successful fetch.
- `ir_valid`, out, 1: one-cycle pulse when `ir` has been updated.
- `inc_pc`, out, 1: one-cycle pulse, coincident with `ir_valid`, drives the PC `IncPC` input.
- `busy`, out, 1: high in every state except IDLE.
- `fetch_err`, out, 1: one-cycle pulse on a misaligned address or a timeout.

## Operation
- States: IDLE, HI, LO, DONE, DRAIN.
- IDLE, `fetch_req=1`, `flush=0`:
  - If `pc_addr[0]=0`: latch the address into `base` and go to HI.
  - If `pc_addr[0]=1`: pulse `fetch_err`, stay in IDLE, make no memory access.
- HI: `mem_addr=base`, `mem_rd=1`. On `mem_ready`, `ir_hi <= mem_rdata` and go to LO.
- LO: `mem_addr=base+1`, `mem_rd=1`. On `mem_ready`, `ir_lo <= mem_rdata` and go to DONE.
- Byte order is big-endian: the even address holds `ir[15:8]`.
- DONE: `ir <= {ir_hi, ir_lo}`, pulse `ir_valid` and `inc_pc`, return to IDLE.
- Address arithmetic is modulo 2^ADDR_W. Because `base` is always even, `base+1` never wraps; `pc_addr=8'hFE` reads 0xFE and 0xFF.
- Flush:
  - In IDLE or DONE: flush cancels the pending IDLE-accept; the DONE pulses still fire.
  - In HI/LO with `mem_ready=1` in the same cycle: the byte is discarded and the FSM goes to IDLE.
  - In HI/LO with `mem_ready=0`: go to DRAIN. `mem_rd` and `mem_addr` stay held until `mem_ready`, then go to IDLE.
  - A flush never updates `ir` and never pulses `ir_valid` or `inc_pc`.
- `fetch_req` and `flush` in the same IDLE cycle: flush wins and the request is dropped.
- `fetch_req` while `busy=1` is ignored. It is not queued.
- Timeout: a wait counter resets on each state entry. If HI/LO/DRAIN waits more than `WAIT_TIMEOUT` cycles, pulse `fetch_err`, drop `mem_rd` and go to IDLE without updating `ir`.

## Timing
- Reset values: `mem_addr=0`, `mem_rd=0`, `ir=16'h0000`, `ir_valid=0`, `inc_pc=0`, `busy=0`, `fetch_err=0`. State is IDLE and the wait counter is 0.
- Zero-wait memory (`mem_ready` tied 1), with request at cycle 0:
  - `mem_rd` high in cycles 1–2.
  - `ir`, `ir_valid` and `inc_pc` visible in cycle 3.
  - Next request accepted in cycle 4.
- Each wait cycle of `mem_ready=0` adds exactly one cycle.
- All outputs are registered or decoded from registered state. There is no combinational path from `mem_ready` to `mem_rd`.
- Reset asserted mid-fetch: immediate return to reset values, with no `inc_pc`.

## Structure
- Shared package `fetch_pkg`:
  - state enum
  - `INSTR_BYTES=2`
  - `PC_STEP=2`
  - the endian convention constant
- The wait/timeout counter is a natural sub-module: `wait_timer`, with clear, enable and expired outputs.

## Test plan
- Zero-wait fetch: memory[0x10]=0xA5, memory[0x11]=0x3C, request at `pc_addr=0x10`.
  - Expect `mem_addr` 0x10 then 0x11.
  - Expect `ir=16'hA53C` with `ir_valid` and `inc_pc` in cycle 3.
- Wait states: `mem_ready` low for 2 cycles on each byte.
  - Expect completion in cycle 7.
  - Expect `mem_addr` and `mem_rd` stable throughout each wait.
- Misaligned request: `pc_addr=0x21`.
  - Expect a `fetch_err` pulse, no `mem_rd`, and `ir` unchanged.
- Flush during LO with `mem_ready=0`:
  - Expect DRAIN with `mem_rd` held.
  - Expect IDLE after `mem_ready`, and no `ir_valid` or `inc_pc`.
- Top of memory: `pc_addr=0xFE` with memory 0xDE/0xAD gives `ir=16'hDEAD`. A timeout (ready never asserted) gives a `fetch_err` pulse after 15 wait cycles.
- Async reset asserted in HI: all outputs are immediately at reset values, and a fresh fetch succeeds after release.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch definitions: FSM states, instruction geometry and byte-order helper.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam int INSTR_BYTES = 2;
  localparam int PC_STEP     = 2;

  // Even address carries the most significant byte of the instruction.
  localparam bit BIG_ENDIAN = 1'b1;

  function automatic logic [INSTR_BYTES*8-1:0] assemble(input logic [7:0] even_byte,
                                                        input logic [7:0] odd_byte);
    return BIG_ENDIAN ? {even_byte, odd_byte} : {odd_byte, even_byte};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch unit bundle: control-unit request side, PC/IR side and byte-wide instruction memory side.
interface instruction_fetch_if #(parameter int ADDR_W = 8);

  logic                                   fetch_req;
  logic [ADDR_W-1:0]                      pc_addr;
  logic                                   flush;
  logic [ADDR_W-1:0]                      mem_addr;
  logic                                   mem_rd;
  logic [7:0]                             mem_rdata;
  logic                                   mem_ready;
  logic [fetch_pkg::INSTR_BYTES*8-1:0]    ir;
  logic                                   ir_valid;
  logic                                   inc_pc;
  logic                                   busy;
  logic                                   fetch_err;

  modport master (
    input  fetch_req, pc_addr, flush, mem_rdata, mem_ready,
    output mem_addr, mem_rd, ir, ir_valid, inc_pc, busy, fetch_err
  );

  modport slave (
    output fetch_req, pc_addr, flush, mem_rdata, mem_ready,
    input  mem_addr, mem_rd, ir, ir_valid, inc_pc, busy, fetch_err
  );

endinterface

// File: rtl/instruction_fetch_wait_timer.sv
// Per-state wait counter: clear restarts it, enable counts, expired flags LIMIT cycles spent waiting.
module wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == CW'(LIMIT));

endmodule

// File: rtl/instruction_fetch.sv
// Two-byte instruction fetch: 3 cycles request-to-ir_valid with zero-wait memory, +1 per mem_ready=0 cycle.
// mem_rd/mem_addr held until mem_ready; fetch_req ignored while busy; waits bounded by WAIT_TIMEOUT.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus
);

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [7:0]        byte_even;
  logic              waiting;
  logic              tmr_clear;
  logic              tmr_expired;

  assign waiting   = (state == S_HI) || (state == S_LO) || (state == S_DRAIN);
  // Any event that leaves the current wait state restarts the count for the next one.
  assign tmr_clear = !waiting || bus.mem_ready || tmr_expired || (bus.flush && state != S_DRAIN);
  assign bus.busy  = (state != S_IDLE);

  wait_timer #(.LIMIT(WAIT_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (waiting),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      base          <= '0;
      byte_even     <= '0;
      bus.mem_addr  <= '0;
      bus.mem_rd    <= 1'b0;
      bus.ir        <= '0;
      bus.ir_valid  <= 1'b0;
      bus.inc_pc    <= 1'b0;
      bus.fetch_err <= 1'b0;
    end else begin
      bus.ir_valid  <= 1'b0;
      bus.inc_pc    <= 1'b0;
      bus.fetch_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.fetch_req && !bus.flush) begin
            if (bus.pc_addr[0]) begin
              bus.fetch_err <= 1'b1;
            end else begin
              base         <= bus.pc_addr;
              bus.mem_addr <= bus.pc_addr;
              bus.mem_rd   <= 1'b1;
              state        <= S_HI;
            end
          end
        end
        S_HI, S_LO: begin
          if (bus.mem_ready) begin
            if (bus.flush) begin
              bus.mem_rd <= 1'b0;
              state      <= S_IDLE;
            end else if (state == S_HI) begin
              byte_even    <= bus.mem_rdata;
              bus.mem_addr <= base + ADDR_W'(1);
              state        <= S_LO;
            end else begin
              bus.ir       <= assemble(byte_even, bus.mem_rdata);
              bus.ir_valid <= 1'b1;
              bus.inc_pc   <= 1'b1;
              bus.mem_rd   <= 1'b0;
              state        <= S_DONE;
            end
          end else if (tmr_expired) begin
            bus.fetch_err <= 1'b1;
            bus.mem_rd    <= 1'b0;
            state         <= S_IDLE;
          end else if (bus.flush) begin
            // Outstanding read must still complete before memory is released.
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (bus.mem_ready) begin
            bus.mem_rd <= 1'b0;
            state      <= S_IDLE;
          end else if (tmr_expired) begin
            bus.fetch_err <= 1'b1;
            bus.mem_rd    <= 1'b0;
            state         <= S_IDLE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: table of fetch vectors scored through an event queue, plus flush/reset sequences.
module tb_instruction_fetch;

  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  instruction_fetch #(.ADDR_W(ADDR_W), .WAIT_TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  int wait_hi = 0;
  int wait_lo = 0;

  typedef struct {
    bit          is_err;
    logic [15:0] ir;
  } exp_t;
  exp_t sb_q[$];
  exp_t sb_e;

  logic [7:0] addr_log[$];
  bit         rd_seen;

  typedef struct {
    logic [7:0]  pc;
    logic [7:0]  d0;
    logic [7:0]  d1;
    int          wh;
    int          wl;
    bit          err;
    logic [15:0] ir;
    int          lat;
    int          nacc;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: answers after wait_hi/wait_lo cycles of mem_ready=0 (negative = never).
  initial begin
    int  wcnt;
    int  lim;
    bit  rd_prev;
    bit  rdy_prev;
    logic [7:0] addr_prev;
    wcnt = 0; rd_prev = 0; rdy_prev = 0; addr_prev = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 8'hEE;
    forever begin
      @(posedge clk);
      #2;
      if (bus.mem_rd) begin
        if (!rd_prev || rdy_prev || bus.mem_addr != addr_prev) wcnt = 0;
        lim = bus.mem_addr[0] ? wait_lo : wait_hi;
        if (lim >= 0 && wcnt >= lim) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem[bus.mem_addr];
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = 8'hEE;
          wcnt++;
        end
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 8'hEE;
      end
      rd_prev   = bus.mem_rd;
      rdy_prev  = bus.mem_ready;
      addr_prev = bus.mem_addr;
    end
  end

  // Monitor: scoreboard pops, hold-while-waiting rule, memory handshake log.
  initial begin
    bit   prev_rd;
    bit   prev_rdy;
    logic [7:0] prev_addr;
    prev_rd = 0; prev_rdy = 0; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.ir_valid || bus.fetch_err) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: ir_valid=%0b fetch_err=%0b ir=0x%0h, none expected",
                     bus.ir_valid, bus.fetch_err, bus.ir);
          end else begin
            sb_e = sb_q.pop_front();
            check("sb_fetch_err", 32'(bus.fetch_err), 32'(sb_e.is_err));
            if (!sb_e.is_err) begin
              check("sb_ir", 32'(bus.ir), 32'(sb_e.ir));
              check("sb_inc_pc", 32'(bus.inc_pc), 32'd1);
            end
          end
        end
        if (prev_rd && !prev_rdy && !bus.fetch_err) begin
          check("hold_mem_rd", 32'(bus.mem_rd), 32'd1);
          check("hold_mem_addr", 32'(bus.mem_addr), 32'(prev_addr));
        end
        if (bus.mem_rd) rd_seen = 1'b1;
        if (bus.mem_rd && bus.mem_ready) addr_log.push_back(bus.mem_addr);
      end
      prev_rd   = reset ? 1'b0 : bus.mem_rd;
      prev_rdy  = bus.mem_ready;
      prev_addr = bus.mem_addr;
    end
  end

  task automatic issue(input logic [7:0] pc);
    @(negedge clk);
    bus.fetch_req = 1'b1;
    bus.pc_addr   = pc;
    @(negedge clk);
    bus.fetch_req = 1'b0;
  endtask

  // Counts cycles from the current negedge (cycle 1 after the request edge) to ir_valid/fetch_err.
  task automatic wait_event(output int lat);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (bus.ir_valid || bus.fetch_err) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [7:0] a1;

    vecs[0] = '{8'h10, 8'hA5, 8'h3C,  0,  0, 1'b0, 16'hA53C,  3, 2};
    vecs[1] = '{8'h20, 8'h12, 8'h34,  2,  2, 1'b0, 16'h1234,  7, 2};
    vecs[2] = '{8'hFE, 8'hDE, 8'hAD,  0,  0, 1'b0, 16'hDEAD,  3, 2};
    vecs[3] = '{8'h21, 8'h99, 8'h99,  0,  0, 1'b1, 16'hDEAD,  1, 0};
    vecs[4] = '{8'h00, 8'h5A, 8'hC3,  1,  0, 1'b0, 16'h5AC3,  4, 2};
    vecs[5] = '{8'h40, 8'h00, 8'hFF, 15,  0, 1'b0, 16'h00FF, 18, 2};
    vecs[6] = '{8'h42, 8'h77, 8'h88,  0, 15, 1'b0, 16'h7788, 18, 2};
    vecs[7] = '{8'h50, 8'h11, 8'h11, -1,  0, 1'b1, 16'h7788, 17, 0};
    vecs[8] = '{8'h60, 8'h22, 8'h22,  0, -1, 1'b1, 16'h7788, 18, 1};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset         = 1'b1;
    bus.fetch_req = 1'b0;
    bus.flush     = 1'b0;
    bus.pc_addr   = '0;
    repeat (3) @(negedge clk);

    check("rst_mem_addr",  32'(bus.mem_addr),  32'h0);
    check("rst_mem_rd",    32'(bus.mem_rd),    32'h0);
    check("rst_ir",        32'(bus.ir),        32'h0);
    check("rst_ir_valid",  32'(bus.ir_valid),  32'h0);
    check("rst_inc_pc",    32'(bus.inc_pc),    32'h0);
    check("rst_busy",      32'(bus.busy),      32'h0);
    check("rst_fetch_err", 32'(bus.fetch_err), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      mem[vecs[i].pc]         = vecs[i].d0;
      mem[vecs[i].pc | 8'h01] = vecs[i].d1;
      wait_hi = vecs[i].wh;
      wait_lo = vecs[i].wl;
      addr_log.delete();
      rd_seen = 1'b0;
      sb_q.push_back('{vecs[i].err, vecs[i].ir});
      issue(vecs[i].pc);
      wait_event(lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_ir", i), 32'(bus.ir), 32'(vecs[i].ir));
      check($sformatf("v%0d_mem_rd_used", i), 32'(rd_seen), 32'(!vecs[i].pc[0]));
      check($sformatf("v%0d_accesses", i), 32'(addr_log.size()), 32'(vecs[i].nacc));
      a1 = vecs[i].pc + 8'd1;
      if (addr_log.size() >= 1) check($sformatf("v%0d_addr_even", i), 32'(addr_log[0]), 32'(vecs[i].pc));
      if (addr_log.size() >= 2) check($sformatf("v%0d_addr_odd", i), 32'(addr_log[1]), 32'(a1));
    end

    // fetch_req raised while busy (odd address) must be neither queued nor flagged.
    mem[8'h70] = 8'h11; mem[8'h71] = 8'h22;
    wait_hi = 2; wait_lo = 0;
    sb_q.push_back('{1'b0, 16'h1122});
    issue(8'h70);
    @(negedge clk);
    bus.fetch_req = 1'b1;
    bus.pc_addr   = 8'h71;
    @(negedge clk);
    bus.fetch_req = 1'b0;
    wait_event(lat);
    check("busy_req_latency", 32'(lat + 2), 32'd5);
    @(negedge clk);
    check("busy_req_not_queued", 32'(bus.busy), 32'd0);
    check("busy_req_no_rd", 32'(bus.mem_rd), 32'd0);

    // Flush in HI coinciding with mem_ready: byte dropped, straight to IDLE.
    wait_hi = 0; wait_lo = 0;
    issue(8'h10);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_hi_busy", 32'(bus.busy), 32'd0);
    check("flush_hi_mem_rd", 32'(bus.mem_rd), 32'd0);
    repeat (2) @(negedge clk);
    check("flush_hi_ir", 32'(bus.ir), 32'h1122);

    // fetch_req and flush together in IDLE: request dropped.
    bus.fetch_req = 1'b1; bus.flush = 1'b1; bus.pc_addr = 8'h10;
    @(negedge clk);
    bus.fetch_req = 1'b0; bus.flush = 1'b0;
    check("req_flush_busy", 32'(bus.busy), 32'd0);
    check("req_flush_mem_rd", 32'(bus.mem_rd), 32'd0);

    // Flush during LO wait: DRAIN holds the read until memory answers.
    mem[8'h80] = 8'h33; mem[8'h81] = 8'h44;
    wait_hi = 0; wait_lo = -1;
    issue(8'h80);
    @(negedge clk);
    check("lo_wait_addr", 32'(bus.mem_addr), 32'h81);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("drain_busy", 32'(bus.busy), 32'd1);
    check("drain_mem_rd", 32'(bus.mem_rd), 32'd1);
    check("drain_mem_addr", 32'(bus.mem_addr), 32'h81);
    wait_lo = 0;
    @(negedge clk);
    check("drain_ready_mem_rd", 32'(bus.mem_rd), 32'd1);
    check("drain_ready_seen", 32'(bus.mem_ready), 32'd1);
    @(negedge clk);
    check("drain_idle_busy", 32'(bus.busy), 32'd0);
    check("drain_idle_mem_rd", 32'(bus.mem_rd), 32'd0);
    check("drain_no_ir_valid", 32'(bus.ir_valid), 32'd0);
    check("drain_no_inc_pc", 32'(bus.inc_pc), 32'd0);
    check("drain_ir_kept", 32'(bus.ir), 32'h1122);

    // Async reset while waiting in HI, then a clean fetch.
    wait_hi = -1; wait_lo = 0;
    issue(8'h10);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("arst_mem_rd",    32'(bus.mem_rd),    32'd0);
    check("arst_mem_addr",  32'(bus.mem_addr),  32'd0);
    check("arst_ir",        32'(bus.ir),        32'd0);
    check("arst_busy",      32'(bus.busy),      32'd0);
    check("arst_ir_valid",  32'(bus.ir_valid),  32'd0);
    check("arst_inc_pc",    32'(bus.inc_pc),    32'd0);
    check("arst_fetch_err", 32'(bus.fetch_err), 32'd0);
    @(negedge clk);
    check("arst_hold_inc_pc", 32'(bus.inc_pc), 32'd0);
    reset = 1'b0;
    wait_hi = 0; wait_lo = 0;
    sb_q.push_back('{1'b0, 16'hA53C});
    issue(8'h10);
    wait_event(lat);
    check("post_rst_latency", 32'(lat), 32'd3);
    check("post_rst_ir", 32'(bus.ir), 32'hA53C);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
